// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and channel FSM state types,
// used by both the slave register block and the matching master.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_WAIT = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Byte-strobed array of 32-bit registers with a one-cycle write strobe per register.
module axi4_lite_regfile #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_strb,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_stb
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            reg_wr_stb <= '0;
        end else begin
            reg_wr_stb <= '0;
            if (wr_en) begin
                // The strobe fires even when no byte lane is enabled
                reg_wr_stb[wr_idx] <= 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (wr_strb[b]) begin
                        regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[32*g +: 32] = regs[g];
    end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; independent write and read
// channel FSMs with one outstanding transaction each.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_stb
);

    localparam int IDX_W = $clog2(NUM_REGS);

    wr_state_t           wr_state;
    logic                aw_done;
    logic                w_done;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [31:0]         w_data_q;
    logic [3:0]          w_strb_q;
    logic                bvalid_q;
    logic [1:0]          bresp_q;

    rd_state_t           rd_state;
    logic                rvalid_q;
    logic [31:0]         rdata_q;
    logic [1:0]          rresp_q;

    logic                aw_hs;
    logic                w_hs;
    logic                aw_have;
    logic                w_have;
    logic                commit;
    logic [ADDR_W-1:0]   wr_addr;
    logic [31:0]         wr_data;
    logic [3:0]          wr_strb;
    logic                wr_in_range;
    logic [IDX_W-1:0]    wr_idx;

    logic                ar_hs;
    logic                rd_in_range;
    logic [IDX_W-1:0]    rd_idx;
    logic                unused_addr_bits;

    // READY is gated by rst so it drops during reset and rises on the first free cycle
    assign S_AXI_AWREADY = !rst && (wr_state != WR_RESP) && !aw_done;
    assign S_AXI_WREADY  = !rst && (wr_state != WR_RESP) && !w_done;
    assign S_AXI_ARREADY = !rst && (rd_state == RD_IDLE);

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;

    assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    assign aw_have = aw_done || aw_hs;
    assign w_have  = w_done || w_hs;
    assign commit  = aw_have && w_have;

    // Commit uses live channel values when the handshake lands on the commit edge
    assign wr_addr     = aw_hs ? S_AXI_AWADDR : aw_addr_q;
    assign wr_data     = w_hs ? S_AXI_WDATA : w_data_q;
    assign wr_strb     = w_hs ? S_AXI_WSTRB : w_strb_q;
    assign wr_in_range = (wr_addr >> (IDX_W + 2)) == '0;
    assign wr_idx      = wr_addr[IDX_W+1:2];

    assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
    assign rd_in_range = (S_AXI_ARADDR >> (IDX_W + 2)) == '0;
    assign rd_idx      = S_AXI_ARADDR[IDX_W+1:2];

    assign unused_addr_bits = ^{wr_addr[1:0], S_AXI_ARADDR[1:0]};

    axi4_lite_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (commit && wr_in_range),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .reg_q      (reg_q),
        .reg_wr_stb (reg_wr_stb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state  <= WR_IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (wr_state)
                WR_IDLE, WR_WAIT: begin
                    if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
                    if (w_hs) begin
                        w_data_q <= S_AXI_WDATA;
                        w_strb_q <= S_AXI_WSTRB;
                    end
                    if (commit) begin
                        wr_state <= WR_RESP;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        aw_done  <= aw_have;
                        w_done   <= w_have;
                        wr_state <= (aw_have || w_have) ? WR_WAIT : WR_IDLE;
                    end
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q <= 1'b0;
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read samples the registered array, so a same-edge write is not yet visible
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state <= RD_DATA;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_in_range ? reg_q[{rd_idx, 5'b0} +: 32] : 32'h0;
                        rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                RD_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q <= 1'b0;
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs: hand-written corner sequences followed
// by a table of write/read-back vectors with hand-computed results.
module tb_axi4_lite_slave_regs;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 32;

    logic                    clk;
    logic                    rst;
    logic [ADDR_W-1:0]       awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [31:0]             wdata;
    logic [3:0]              wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_W-1:0]       araddr;
    logic                    arvalid;
    logic                    arready;
    logic [31:0]             rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [32*NUM_REGS-1:0]  reg_q;
    logic [NUM_REGS-1:0]     reg_wr_stb;

    axi4_lite_slave_regs #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_q         (reg_q),
        .reg_wr_stb    (reg_wr_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_bresp;
        logic [7:0]  exp_stb;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [NUM_REGS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: actual timeout required handshake", name);
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < NUM_REGS; i++) begin
            check($sformatf("%s reg%0d", name, i), reg_q[32*i +: 32], model[i]);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [7:0] stb, output int lat);
        bit aw_f, w_f, found;
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            @(negedge clk);
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            step();
            if (aw_f) awvalid = 1'b0;
            if (w_f)  wvalid  = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            timeout_fail("write addr/data handshake");
            awvalid = 1'b0; wvalid = 1'b0;
        end
        lat = 0; found = 1'b0;
        while (!found && lat < 20) begin
            @(negedge clk);
            if (bvalid) found = 1'b1;
            else lat++;
        end
        if (!found) timeout_fail("write response");
        resp = bresp;
        stb  = reg_wr_stb;
        step();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ar_f, found;
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            @(negedge clk);
            ar_f = arready;
            step();
            if (ar_f) arvalid = 1'b0;
            n++;
        end
        if (arvalid) begin
            timeout_fail("read addr handshake");
            arvalid = 1'b0;
        end
        n = 0; found = 1'b0;
        while (!found && n < 20) begin
            @(negedge clk);
            if (rvalid) found = 1'b1;
            else n++;
        end
        if (!found) timeout_fail("read data");
        data = rdata;
        resp = rresp;
        step();
        rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running required finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [7];
        logic [1:0]  resp;
        logic [7:0]  stb;
        logic [31:0] data;
        int          lat;

        vecs[0] = '{32'h00, 32'hCAFEF00D, 4'b1111, 2'b00, 8'h01, 32'h00, 32'hCAFEF00D, 2'b00};
        vecs[1] = '{32'h00, 32'h11223344, 4'b0011, 2'b00, 8'h01, 32'h00, 32'hCAFE3344, 2'b00};
        vecs[2] = '{32'h1F, 32'hAABBCCDD, 4'b1100, 2'b00, 8'h80, 32'h1C, 32'hAABB0000, 2'b00};
        vecs[3] = '{32'h0C, 32'hFFFFFFFF, 4'b0000, 2'b00, 8'h08, 32'h0C, 32'h12345678, 2'b00};
        vecs[4] = '{32'h40, 32'h55555555, 4'b1111, 2'b10, 8'h00, 32'h40, 32'h00000000, 2'b10};
        vecs[5] = '{32'h14, 32'h0000BEEF, 4'b0110, 2'b00, 8'h20, 32'h14, 32'h0000BE00, 2'b00};
        vecs[6] = '{32'h0C, 32'h87654321, 4'b1000, 2'b00, 8'h08, 32'h0C, 32'h87345678, 2'b00};

        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        clear_model();

        // Reset state
        repeat (3) step();
        @(negedge clk);
        check("reset awready", awready, 0);
        check("reset wready", wready, 0);
        check("reset arready", arready, 0);
        check("reset bvalid", bvalid, 0);
        check("reset rvalid", rvalid, 0);
        check("reset rdata", rdata, 0);
        check("reset stb", reg_wr_stb, 0);
        check_regs("reset");
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post-reset awready", awready, 1);
        check("post-reset wready", wready, 1);
        check("post-reset arready", arready, 1);
        step();

        // Same-cycle AW+W write
        axi_write(32'h4, 32'hDEADBEEF, 4'b1111, resp, stb, lat);
        model[1] = 32'hDEADBEEF;
        check("aw+w bvalid latency", lat, 0);
        check("aw+w bresp", resp, 2'b00);
        check("aw+w stb", stb, 8'h02);
        @(negedge clk);
        check("aw+w stb one cycle", reg_wr_stb, 0);
        check("aw+w bvalid cleared", bvalid, 0);
        check_regs("aw+w");

        // Read with RREADY held low: data must hold, ARREADY low
        araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
        step();
        arvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rd hold rvalid", rvalid, 1);
            check("rd hold rdata", rdata, 32'hDEADBEEF);
            check("rd hold arready", arready, 0);
            step();
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        @(negedge clk);
        check("rd done rvalid", rvalid, 0);
        check("rd done arready", arready, 1);
        step();

        // W three cycles ahead of AW, partial strobes, BREADY held low
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        check("w-first wready", wready, 1);
        step();
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("w-first wready low", wready, 0);
            check("w-first awready", awready, 1);
            check("w-first bvalid low", bvalid, 0);
            step();
        end
        awaddr = 32'h8; awvalid = 1'b1;
        @(negedge clk);
        check("w-first aw accept", awready, 1);
        step();
        awvalid = 1'b0;
        model[2] = 32'h00220044;
        @(negedge clk);
        check("w-first bvalid", bvalid, 1);
        check("w-first bresp", bresp, 2'b00);
        check("w-first wready resp", wready, 0);
        check("w-first stb", reg_wr_stb, 8'h04);
        check_regs("w-first");
        step();
        bready = 1'b1;
        @(negedge clk);
        check("w-first bvalid held", bvalid, 1);
        check("w-first wready held", wready, 0);
        step();
        bready = 1'b0;
        @(negedge clk);
        check("w-first bvalid done", bvalid, 0);
        check("w-first wready back", wready, 1);
        step();

        // BREADY stalled five cycles
        awaddr = 32'h10; wdata = 32'h0BADCAFE; wstrb = 4'b1111;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        model[4] = 32'h0BADCAFE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d bvalid", i), bvalid, 1);
            check($sformatf("stall%0d bresp", i), bresp, 2'b00);
            check($sformatf("stall%0d awready", i), awready, 0);
            check($sformatf("stall%0d wready", i), wready, 0);
            step();
        end
        bready = 1'b1;
        @(negedge clk);
        check("stall6 bvalid", bvalid, 1);
        step();
        bready = 1'b0;
        @(negedge clk);
        check("stall done bvalid", bvalid, 0);
        check("stall done awready", awready, 1);
        check_regs("stall");
        step();

        // Out-of-range read and write
        axi_read(32'h20, data, resp);
        check("oor read rresp", resp, 2'b10);
        check("oor read rdata", data, 0);
        axi_write(32'h24, 32'hFFFFFFFF, 4'b1111, resp, stb, lat);
        check("oor write bresp", resp, 2'b10);
        check("oor write stb", stb, 0);
        check_regs("oor write");

        // Write commit and AR to the same register on one edge
        awaddr = 32'h0; wdata = 32'hA5A5A5A5; wstrb = 4'b1111; araddr = 32'h0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        check("coll all ready", {awready, wready, arready}, 3'b111);
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model[0] = 32'hA5A5A5A5;
        @(negedge clk);
        check("coll bvalid", bvalid, 1);
        check("coll rvalid", rvalid, 1);
        check("coll rdata old", rdata, 32'h0);
        step();
        bready = 1'b0; rready = 1'b0;
        axi_read(32'h0, data, resp);
        check("coll reread", data, 32'hA5A5A5A5);

        // Reset after AW-only capture
        awaddr = 32'hC; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        @(negedge clk);
        check("aw-only awready low", awready, 0);
        check("aw-only wready", wready, 1);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("mid reset awready", awready, 0);
        step();
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        check("abandon awready", awready, 1);
        check("abandon wready", wready, 1);
        check("abandon arready", arready, 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abandon bvalid%0d", i), bvalid, 0);
            step();
            @(negedge clk);
        end
        check_regs("abandon");
        step();
        axi_write(32'hC, 32'h12345678, 4'b1111, resp, stb, lat);
        model[3] = 32'h12345678;
        check("after reset bresp", resp, 2'b00);
        check("after reset stb", stb, 8'h08);
        check_regs("after reset");

        // Table of write/read-back vectors
        for (int i = 0; i < 7; i++) begin
            axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, resp, stb, lat);
            check($sformatf("vec%0d bresp", i), resp, vecs[i].exp_bresp);
            check($sformatf("vec%0d stb", i), stb, vecs[i].exp_stb);
            check($sformatf("vec%0d latency", i), lat, 0);
            if (vecs[i].exp_bresp == 2'b00) model[int'(vecs[i].raddr[4:2])] = vecs[i].exp_rdata;
            axi_read(vecs[i].raddr, data, resp);
            check($sformatf("vec%0d rdata", i), data, vecs[i].exp_rdata);
            check($sformatf("vec%0d rresp", i), resp, vecs[i].exp_rresp);
            check_regs($sformatf("vec%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

Interface
REQ-001 Parameter NUM_REGS, default 8, number of 32-bit registers (power of two, 2..64) SHALL set the register count.
REQ-002 Parameter ADDR_W, default 32, AXI address width SHALL set the width of AWADDR and ARADDR.
REQ-003 Port clk, input, 1, system clock SHALL clock all state on its rising edge.
REQ-004 Port rst, input, 1, reset SHALL be synchronous and active-high.
REQ-005 Write address channel ports SHALL be: S_AXI_AWADDR in ADDR_W; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-006 Write data channel ports SHALL be: S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-007 Write response channel ports SHALL be: S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-008 Read address channel ports SHALL be: S_AXI_ARADDR in ADDR_W; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-009 Read data channel ports SHALL be: S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-010 Port reg_q, output, 32*NUM_REGS, SHALL carry the live register contents, with register i at bits [32i+31:32i].
REQ-011 Port reg_wr_stb, output, NUM_REGS, SHALL pulse bit i for one cycle when register i is written.

Function
REQ-012 Decode: word index = ADDR[log2(NUM_REGS)+1:2]; bits [1:0] ignored; addresses at or above NUM_REGS*4 are out of range.
REQ-013 Write path SHALL be an FSM with states WR_IDLE, WR_WAIT, WR_RESP.
REQ-014 In WR_IDLE/WR_WAIT, AWREADY SHALL be high while AW is not yet captured, and WREADY SHALL be high while W is not yet captured.
REQ-015 AW and W SHALL be captured independently in any order or in the same cycle; WR_WAIT holds while exactly one of them is captured.
REQ-016 On the edge where both AW and W are captured, the write SHALL commit and the FSM SHALL enter WR_RESP with BVALID=1 on the next cycle (min latency: same-cycle AW+W handshake -> BVALID one cycle later).
REQ-017 Commit SHALL update only the bytes whose WSTRB bit is 1; WSTRB=0000 SHALL be accepted as a no-op with BRESP=OKAY, and reg_wr_stb SHALL still pulse.
REQ-018 An out-of-range write SHALL discard data, leave reg_wr_stb low, and return BRESP=SLVERR (2'b10); in range returns OKAY (2'b00).
REQ-019 In WR_RESP, AWREADY and WREADY SHALL be 0, and BVALID/BRESP SHALL hold stable until BREADY; on the BVALID&BREADY edge -> WR_IDLE.
REQ-020 Read path SHALL be an FSM with states RD_IDLE, RD_DATA.
REQ-021 In RD_IDLE, ARREADY=1; the AR handshake SHALL latch RDATA/RRESP and enter RD_DATA with RVALID=1 on the next cycle.
REQ-022 In RD_DATA, ARREADY=0 and RVALID/RDATA/RRESP SHALL hold stable until RREADY; on RVALID&RREADY -> RD_IDLE.
REQ-023 An out-of-range read SHALL return RDATA=0 with RRESP=SLVERR.
REQ-024 The read and write paths SHALL run concurrently; if a write commit and an AR handshake hit the same register on the same edge, the read SHALL return the pre-write value.
REQ-025 At most one outstanding write and one outstanding read; no interleaving or reordering is possible.

Reset
REQ-026 While rst=1 at a clock edge: both FSMs -> idle, capture flags cleared, all registers 0, outputs zero, READY and VALID outputs 0, RDATA 0, RESP 0, reg_wr_stb 0.
REQ-027 On the first cycle after rst deasserts, AWREADY, WREADY and ARREADY SHALL be 1.
REQ-028 Reset mid-transaction SHALL abandon it silently: no BVALID/RVALID afterwards, and the partially captured write is not committed.

Structure
REQ-029 Package axi4_lite_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants and the wr_state_t/rd_state_t enums, shared with the master.
REQ-030 One sub-module, axi4_lite_regfile (byte-strobed register array with reg_wr_stb generation), SHALL be instantiated; the FSMs stay in the top level.

Verification
REQ-031 Same-cycle AW+W, addr 0x4, data 0xDEADBEEF, strb 1111, BREADY=1 -> BVALID next cycle, BRESP=00, reg_q[63:32]=0xDEADBEEF, reg_wr_stb=0x02 for one cycle.
REQ-032 W three cycles before AW, addr 0x8, strb 0101 over 0x11223344 (reg=0) -> reg 2 = 0x00220044, WREADY low after the W handshake until BREADY.
REQ-033 BREADY held low 5 cycles -> BVALID/BRESP stable, AWREADY/WREADY=0 throughout; accepted on cycle 6.
REQ-034 Read 0x20 with NUM_REGS=8 -> RRESP=10, RDATA=0; write 0x24 -> BRESP=10, no reg_q change.
REQ-035 Write 0xA5A5A5A5 to 0x0 committing on the same edge as an AR to 0x0 -> RDATA=old value 0; the next read returns 0xA5A5A5A5.
REQ-036 rst asserted after AW-only capture -> no BVALID; the subsequent full write completes normally with all registers reset to 0.
